lcd_refresh_ctrl: RTL and testbench
===================================

# lcd_refresh_ctrl

Sequencing driver for the DE2-115 character LCD (HD44780-compatible, 8-bit bus, write-only). It powers up and initialises the panel, then refreshes both 16-character lines continuously. For each position it presents a character index 0–31 to the text/data lookup block and fetches the returned byte. Raw nibble values 0x00–0x0F are converted to ASCII hex digits before the byte is strobed onto the LCD pins.

## Interface
Parameters (all counts in `clk` cycles, defaults for 50 MHz):
- `T_POWERUP`, default 1_000_000: wait after reset before the first command (20 ms).
- `T_SETUP`, default 4: RS/DATA stable before EN rises; must be ≥ 2.
- `T_EN`, default 16: EN high width.
- `T_HOLD`, default 4: RS/DATA held after EN falls.
- `T_CMD`, default 2_500: settle after any byte other than clear (50 µs).
- `T_CLEAR`, default 100_000: settle after the clear command 0x01 (2 ms).

Ports:
- `clk` input 1: single system clock. All logic is on the rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `lcd_index` output 8: character position requested from the lookup block. Range 0–15 is line 1, range 16–31 is line 2.
- `lcd_char` input 8: character byte returned combinationally for `lcd_index`.
- `lcd_data` output 8: LCD data bus.
- `lcd_rs` output 1: 0 selects command, 1 selects data.
- `lcd_rw` output 1: constant 0 (write-only).
- `lcd_en` output 1: LCD enable strobe.
- `lcd_on` output 1: panel power, constant 1.
- `lcd_blon` output 1: backlight, constant 0 (the DE2-115 panel has none).
- `ready` output 1: high once initialisation has completed.

## Operation
- Reset values: `lcd_index`=0, `lcd_data`=0x00, `lcd_rs`=0, `lcd_en`=0, `ready`=0. `lcd_rw`/`lcd_on`/`lcd_blon` are constants.
- Top-level FSM states: POWERUP → INIT → LINE1_ADDR → LINE1_CHARS → LINE2_ADDR → LINE2_CHARS → LINE1_ADDR, looping forever.
- POWERUP: counts `T_POWERUP` cycles, then enters INIT.
- INIT issues four commands in order, each with `lcd_rs`=0:
  - 0x38: function set, 8-bit, 2 lines, 5×8 font.
  - 0x0C: display on, cursor off.
  - 0x01: clear.
  - 0x06: entry mode, increment, no shift.
- `ready` rises in the cycle the FSM first enters LINE1_ADDR. It stays high until reset.
- LINE1_ADDR sends command 0x80. LINE2_ADDR sends command 0xC0.
- LINEn_CHARS sends 16 data bytes with `lcd_rs`=1:
  - LINE1_CHARS uses indices 0–15; LINE2_CHARS uses 16–31.
  - After index 31, the next pass starts again at 0.
- Character conversion, applied to `lcd_char` as it is latched:
  - 0x00–0x09 becomes 0x30–0x39.
  - 0x0A–0x0F becomes 0x41–0x46 (uppercase).
  - 0x10–0xFF passes through unchanged.
- Byte-write sub-sequence, used for every command and data byte:
  - SETUP for `T_SETUP` cycles. `lcd_index` is updated in the first SETUP cycle. The converted `lcd_char` is registered onto `lcd_data` on the last SETUP cycle.
  - EN_HI for `T_EN` cycles with `lcd_en`=1.
  - HOLD for `T_HOLD` cycles with `lcd_en`=0 and data unchanged.
  - WAIT for `T_CLEAR` cycles after 0x01, otherwise `T_CMD` cycles.
- `lcd_index` is driven during command bytes too. It holds the value of the last data byte (0 before the first one); the lookup result is ignored.
- `n` may change at any time. Each byte reflects `lcd_char` as sampled on the last SETUP cycle. No frame-level coherence is guaranteed.

## Timing
- One byte takes exactly `T_SETUP + T_EN + T_HOLD + T_WAIT` cycles, where `T_WAIT` is `T_CMD` or `T_CLEAR`.
- `lcd_data` and `lcd_rs` are stable for the whole EN-high window, plus `T_HOLD` after it.
- `lcd_en` rises exactly `T_SETUP` cycles after `lcd_index` changes.
- All LCD outputs are registered; there are no combinational paths to the pins.
- The `lcd_char` → `lcd_data` path is one combinational lookup plus the conversion, within one cycle.
- First `lcd_en` rise occurs at cycle `T_POWERUP + T_SETUP` after reset release.
- One full refresh of both lines (2 address bytes + 32 data bytes) takes 34 × (`T_SETUP + T_EN + T_HOLD + T_CMD`) cycles.
- Reset asserted mid-operation:
  - Outputs return to their reset values asynchronously, including `lcd_en` dropping immediately.
  - After release the block restarts from POWERUP with a full re-initialisation.

## Structure
- Shared package `lcd_pkg` holds:
  - Command constants `LCD_FUNC_SET`=0x38, `LCD_DISP_ON`=0x0C, `LCD_CLEAR`=0x01, `LCD_ENTRY`=0x06, `LCD_LINE1`=0x80, `LCD_LINE2`=0xC0.
  - The top-level FSM state enum.
  - The nibble-to-ASCII function.
- Sub-module `lcd_byte_writer` owns the SETUP/EN_HI/HOLD/WAIT counter:
  - Handshake: `start` with `rs`/`byte`/`is_clear`; `done` pulses for one cycle at the end of WAIT.
  - The top-level FSM issues `start` only in the cycle after `done`.
- One down-counter is sized by `$clog2` of the largest timing parameter.

## Test plan
Run with the parameters reduced: `T_POWERUP`=20, `T_CMD`=10, `T_CLEAR`=30, with the text/data lookup instantiated as the `lcd_char` source.
- Reset: hold `reset_n`=0 for 5 cycles → `lcd_en`=0, `lcd_data`=0x00, `lcd_rs`=0, `lcd_index`=0, `ready`=0. First `lcd_en` rise occurs at cycle 24 after release.
- Init sequence: capture bytes on `lcd_en` falling → 0x38, 0x0C, 0x01, 0x06 with `rs`=0. The gap after 0x01 is 30 WAIT cycles; after the others it is 10. `ready` rises on entering the line-1 address.
- Line 1 with `n`=0x4A → 0x80 (rs=0), then `H` `E` `X` `:` ` ` `4` `A` followed by nine 0x20, all with rs=1.
- Line 2 with `n`=0x4A → 0xC0, then `c` `h` `a` `r` `:` ` ` `J` followed by nine 0x20. Indices 16–31 appear in order, then wrap to 0.
- Conversion boundaries:
  - `n`=0x9F → line-1 positions 5/6 show 0x39 and 0x46.
  - `n`=0x0A → position 22 shows 0x41 (nibble value, converted).
  - `n`=0x10 → position 22 shows 0x10 unchanged.
- Reset pulsed during EN_HI of a data byte → `lcd_en` drops within the same cycle. After release the bench sees POWERUP then the full init sequence again.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared definitions for the character-LCD refresh controller: HD44780 command bytes,
// state encodings and the nibble-to-ASCII conversion applied to fetched characters.
package lcd_pkg;

    localparam logic [7:0] LCD_FUNC_SET = 8'h38;
    localparam logic [7:0] LCD_DISP_ON  = 8'h0C;
    localparam logic [7:0] LCD_CLEAR    = 8'h01;
    localparam logic [7:0] LCD_ENTRY    = 8'h06;
    localparam logic [7:0] LCD_LINE1    = 8'h80;
    localparam logic [7:0] LCD_LINE2    = 8'hC0;

    localparam logic [3:0] LAST_INIT_STEP = 4'd3;
    localparam logic [3:0] LAST_CHAR_STEP = 4'd15;

    typedef enum logic [2:0] {
        ST_POWERUP,
        ST_INIT,
        ST_LINE1_ADDR,
        ST_LINE1_CHARS,
        ST_LINE2_ADDR,
        ST_LINE2_CHARS
    } lcd_state_e;

    typedef enum logic [2:0] {
        WR_IDLE,
        WR_SETUP,
        WR_EN_HI,
        WR_HOLD,
        WR_WAIT
    } wr_state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Counters hold (count - 1), so $clog2(count) bits suffice; never go below one bit.
    function automatic int cnt_width(input int max_count);
        return (max_count > 1) ? $clog2(max_count) : 1;
    endfunction

    function automatic logic [7:0] nibble_to_ascii(input logic [7:0] c);
        logic [7:0] r;
        if (c < 8'h0A) begin
            r = c + 8'h30;
        end else if (c < 8'h10) begin
            r = c + 8'h37;
        end else begin
            r = c;
        end
        return r;
    endfunction

endpackage

// File: rtl/lcd_byte_writer.sv
// Drives one HD44780 write cycle (SETUP, EN_HI, HOLD, WAIT) from a single down-counter.
// The cycle in which start is seen counts as the first SETUP cycle.
module lcd_byte_writer
    import lcd_pkg::*;
#(
    parameter int T_SETUP = 4,
    parameter int T_EN    = 16,
    parameter int T_HOLD  = 4,
    parameter int T_CMD   = 2_500,
    parameter int T_CLEAR = 100_000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       rs,
    input  logic [7:0] wr_byte,
    input  logic       is_clear,
    output logic       done,
    output logic [7:0] lcd_data,
    output logic       lcd_rs,
    output logic       lcd_en
);

    localparam int T_MAX = max_int(max_int(max_int(T_SETUP, T_EN), max_int(T_HOLD, T_CMD)), T_CLEAR);
    localparam int CW    = cnt_width(T_MAX);

    wr_state_e     state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          clear_q, clear_nxt;
    logic          en_nxt, rs_nxt;
    logic [7:0]    data_nxt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= WR_IDLE;
            cnt      <= '0;
            clear_q  <= 1'b0;
            lcd_en   <= 1'b0;
            lcd_rs   <= 1'b0;
            lcd_data <= 8'h00;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            clear_q  <= clear_nxt;
            lcd_en   <= en_nxt;
            lcd_rs   <= rs_nxt;
            lcd_data <= data_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            WR_IDLE: begin
                if (start) begin
                    state_nxt = WR_SETUP;
                    cnt_nxt   = CW'(T_SETUP - 2);
                end
            end
            WR_SETUP: begin
                if (cnt == '0) begin
                    state_nxt = WR_EN_HI;
                    cnt_nxt   = CW'(T_EN - 1);
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            WR_EN_HI: begin
                if (cnt == '0) begin
                    state_nxt = WR_HOLD;
                    cnt_nxt   = CW'(T_HOLD - 1);
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            WR_HOLD: begin
                if (cnt == '0) begin
                    state_nxt = WR_WAIT;
                    cnt_nxt   = clear_q ? CW'(T_CLEAR - 1) : CW'(T_CMD - 1);
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            WR_WAIT: begin
                if (cnt == '0) begin
                    state_nxt = WR_IDLE;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            default: begin
                state_nxt = WR_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Data is captured at the end of SETUP, so it reflects lcd_char in the last SETUP cycle.
    always_comb begin
        en_nxt    = lcd_en;
        rs_nxt    = lcd_rs;
        data_nxt  = lcd_data;
        clear_nxt = clear_q;
        done      = 1'b0;
        case (state)
            WR_IDLE: begin
                if (start) begin
                    rs_nxt    = rs;
                    clear_nxt = is_clear;
                end
            end
            WR_SETUP: begin
                if (cnt == '0) begin
                    en_nxt   = 1'b1;
                    data_nxt = wr_byte;
                end
            end
            WR_EN_HI: begin
                if (cnt == '0) begin
                    en_nxt = 1'b0;
                end
            end
            WR_WAIT: begin
                done = (cnt == '0);
            end
            default: begin
                en_nxt = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/lcd_refresh_ctrl.sv
// Power-up, initialisation and continuous two-line refresh of an HD44780 character LCD.
// state          | meaning
// ST_POWERUP     | wait T_POWERUP cycles after reset
// ST_INIT        | send 0x38, 0x0C, 0x01, 0x06
// ST_LINE1_ADDR  | send DDRAM address 0x80
// ST_LINE1_CHARS | send characters for indices 0-15
// ST_LINE2_ADDR  | send DDRAM address 0xC0
// ST_LINE2_CHARS | send characters for indices 16-31
module lcd_refresh_ctrl
    import lcd_pkg::*;
#(
    parameter int T_POWERUP = 1_000_000,
    parameter int T_SETUP   = 4,
    parameter int T_EN      = 16,
    parameter int T_HOLD    = 4,
    parameter int T_CMD     = 2_500,
    parameter int T_CLEAR   = 100_000
) (
    input  logic       clk,
    input  logic       reset_n,
    output logic [7:0] lcd_index,
    input  logic [7:0] lcd_char,
    output logic [7:0] lcd_data,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_en,
    output logic       lcd_on,
    output logic       lcd_blon,
    output logic       ready
);

    localparam int PW = cnt_width(T_POWERUP);

    lcd_state_e    state, state_nxt;
    logic [3:0]    step, step_nxt;
    logic [PW-1:0] pu_cnt, pu_cnt_nxt;
    logic          start, start_nxt;
    logic [7:0]    index_nxt;
    logic          ready_nxt;
    logic          wr_rs, wr_clear, done;
    logic [7:0]    wr_byte;

    assign lcd_rw   = 1'b0;
    assign lcd_on   = 1'b1;
    assign lcd_blon = 1'b0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_POWERUP;
            step      <= 4'd0;
            pu_cnt    <= PW'(T_POWERUP - 1);
            start     <= 1'b0;
            lcd_index <= 8'd0;
            ready     <= 1'b0;
        end else begin
            state     <= state_nxt;
            step      <= step_nxt;
            pu_cnt    <= pu_cnt_nxt;
            start     <= start_nxt;
            lcd_index <= index_nxt;
            ready     <= ready_nxt;
        end
    end

    // start and lcd_index update together, so the new index is valid throughout SETUP.
    always_comb begin
        state_nxt  = state;
        step_nxt   = step;
        pu_cnt_nxt = pu_cnt;
        start_nxt  = 1'b0;
        index_nxt  = lcd_index;
        case (state)
            ST_POWERUP: begin
                if (pu_cnt == '0) begin
                    state_nxt = ST_INIT;
                    step_nxt  = 4'd0;
                    start_nxt = 1'b1;
                end else begin
                    pu_cnt_nxt = pu_cnt - PW'(1);
                end
            end
            ST_INIT: begin
                if (done) begin
                    start_nxt = 1'b1;
                    if (step == LAST_INIT_STEP) begin
                        state_nxt = ST_LINE1_ADDR;
                        step_nxt  = 4'd0;
                    end else begin
                        step_nxt = step + 4'd1;
                    end
                end
            end
            ST_LINE1_ADDR: begin
                if (done) begin
                    state_nxt = ST_LINE1_CHARS;
                    step_nxt  = 4'd0;
                    start_nxt = 1'b1;
                    index_nxt = 8'd0;
                end
            end
            ST_LINE1_CHARS: begin
                if (done) begin
                    start_nxt = 1'b1;
                    if (step == LAST_CHAR_STEP) begin
                        state_nxt = ST_LINE2_ADDR;
                    end else begin
                        step_nxt  = step + 4'd1;
                        index_nxt = {4'd0, step + 4'd1};
                    end
                end
            end
            ST_LINE2_ADDR: begin
                if (done) begin
                    state_nxt = ST_LINE2_CHARS;
                    step_nxt  = 4'd0;
                    start_nxt = 1'b1;
                    index_nxt = 8'd16;
                end
            end
            ST_LINE2_CHARS: begin
                if (done) begin
                    start_nxt = 1'b1;
                    if (step == LAST_CHAR_STEP) begin
                        state_nxt = ST_LINE1_ADDR;
                    end else begin
                        step_nxt  = step + 4'd1;
                        index_nxt = {4'd1, step + 4'd1};
                    end
                end
            end
            default: begin
                state_nxt = ST_POWERUP;
            end
        endcase
        ready_nxt = ready | (state_nxt == ST_LINE1_ADDR);
    end

    always_comb begin
        wr_rs    = 1'b0;
        wr_byte  = 8'h00;
        case (state)
            ST_INIT: begin
                case (step)
                    4'd0:    wr_byte = LCD_FUNC_SET;
                    4'd1:    wr_byte = LCD_DISP_ON;
                    4'd2:    wr_byte = LCD_CLEAR;
                    default: wr_byte = LCD_ENTRY;
                endcase
            end
            ST_LINE1_ADDR: wr_byte = LCD_LINE1;
            ST_LINE2_ADDR: wr_byte = LCD_LINE2;
            ST_LINE1_CHARS, ST_LINE2_CHARS: begin
                wr_rs   = 1'b1;
                wr_byte = nibble_to_ascii(lcd_char);
            end
            default: wr_byte = 8'h00;
        endcase
        wr_clear = !wr_rs && (wr_byte == LCD_CLEAR);
    end

    lcd_byte_writer #(
        .T_SETUP (T_SETUP),
        .T_EN    (T_EN),
        .T_HOLD  (T_HOLD),
        .T_CMD   (T_CMD),
        .T_CLEAR (T_CLEAR)
    ) u_writer (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .rs       (wr_rs),
        .wr_byte  (wr_byte),
        .is_clear (wr_clear),
        .done     (done),
        .lcd_data (lcd_data),
        .lcd_rs   (lcd_rs),
        .lcd_en   (lcd_en)
    );

endmodule

// File: tb/tb_lcd_refresh_ctrl.sv
// Bench for lcd_refresh_ctrl: a text lookup of "HEX: nn" / "char: c" driven by n,
// and an expected byte stream built from the display protocol rules.
module tb_lcd_refresh_ctrl;

    localparam int T_POWERUP = 20;
    localparam int T_SETUP   = 4;
    localparam int T_EN      = 16;
    localparam int T_HOLD    = 4;
    localparam int T_CMD     = 10;
    localparam int T_CLEAR   = 30;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] lcd_index, lcd_char, lcd_data;
    logic       lcd_rs, lcd_rw, lcd_en, lcd_on, lcd_blon, ready;
    logic [7:0] n = 8'h4A;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int rel_cyc = 0;
    int prev_rise = 0;
    int prev_wait = 0;
    int have_prev = 0;
    int last_rise = 0;
    int addr_rise = 0;
    int idx_chg_cyc = 0;
    int ready_rise_cyc = -1;
    logic [7:0] model_idx = 8'd0;
    logic [7:0] idx_prev = 8'd0;
    logic       rdy_prev = 1'b0;
    logic [7:0] line_got [32];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] lookup(input logic [7:0] idx, input logic [7:0] nv);
        logic [7:0] r;
        r = 8'h20;
        case (idx)
            8'd0:  r = "H";
            8'd1:  r = "E";
            8'd2:  r = "X";
            8'd3:  r = ":";
            8'd5:  r = {4'h0, nv[7:4]};
            8'd6:  r = {4'h0, nv[3:0]};
            8'd16: r = "c";
            8'd17: r = "h";
            8'd18: r = "a";
            8'd19: r = "r";
            8'd20: r = ":";
            8'd22: r = nv;
            default: r = 8'h20;
        endcase
        return r;
    endfunction

    assign lcd_char = lookup(lcd_index, n);

    function automatic logic [7:0] conv(input logic [7:0] c);
        string hx;
        hx = "0123456789ABCDEF";
        if (c < 8'd16) return 8'(hx[int'(c)]);
        return c;
    endfunction

    always @(negedge clk) begin
        if (lcd_index !== idx_prev) idx_chg_cyc = cyc;
        idx_prev = lcd_index;
        if (ready === 1'b1 && rdy_prev !== 1'b1) ready_rise_cyc = cyc;
        rdy_prev = ready;
    end

    lcd_refresh_ctrl #(
        .T_POWERUP (T_POWERUP),
        .T_SETUP   (T_SETUP),
        .T_EN      (T_EN),
        .T_HOLD    (T_HOLD),
        .T_CMD     (T_CMD),
        .T_CLEAR   (T_CLEAR)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .lcd_index (lcd_index),
        .lcd_char  (lcd_char),
        .lcd_data  (lcd_data),
        .lcd_rs    (lcd_rs),
        .lcd_rw    (lcd_rw),
        .lcd_en    (lcd_en),
        .lcd_on    (lcd_on),
        .lcd_blon  (lcd_blon),
        .ready     (ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_byte(input string tag, input logic [7:0] e_d, input logic e_rs,
                               input logic [7:0] e_idx, input logic e_rdy, output logic [7:0] got);
        logic [7:0] d;
        logic       r;
        logic       stable;
        int         t, w, rise;
        t = 0;
        got = 8'h00;
        while (lcd_en !== 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk($sformatf("%s_en_rise", tag), {31'd0, lcd_en}, 32'd1);
        if (lcd_en !== 1'b1) return;
        rise = cyc;
        d = lcd_data;
        r = lcd_rs;
        got = d;
        chk($sformatf("%s_data", tag), {24'd0, d}, {24'd0, e_d});
        chk($sformatf("%s_rs", tag), {31'd0, r}, {31'd0, e_rs});
        chk($sformatf("%s_index", tag), {24'd0, lcd_index}, {24'd0, e_idx});
        chk($sformatf("%s_ready", tag), {31'd0, ready}, {31'd0, e_rdy});
        if (have_prev != 0)
            chk($sformatf("%s_period", tag), rise - prev_rise, T_SETUP + T_EN + T_HOLD + prev_wait);
        else
            chk($sformatf("%s_first_rise", tag), rise - rel_cyc, T_POWERUP + T_SETUP);
        if (e_rs && e_idx != model_idx)
            chk($sformatf("%s_idx_to_en", tag), rise - idx_chg_cyc, T_SETUP);
        w = 0;
        stable = 1'b1;
        while (lcd_en === 1'b1 && w < 100) begin
            if (lcd_data !== d || lcd_rs !== r) stable = 1'b0;
            w++;
            @(negedge clk);
        end
        chk($sformatf("%s_en_width", tag), w, T_EN);
        for (int i = 0; i < T_HOLD; i++) begin
            if (lcd_data !== d || lcd_rs !== r || lcd_en !== 1'b0) stable = 1'b0;
            @(negedge clk);
        end
        chk($sformatf("%s_stable", tag), {31'd0, stable}, 32'd1);
        prev_rise = rise;
        prev_wait = (!e_rs && e_d == 8'h01) ? T_CLEAR : T_CMD;
        have_prev = 1;
        last_rise = rise;
        if (e_rs) model_idx = e_idx;
    endtask

    task automatic do_init();
        logic [7:0] g;
        expect_byte("init_func", 8'h38, 1'b0, model_idx, 1'b0, g);
        expect_byte("init_disp", 8'h0C, 1'b0, model_idx, 1'b0, g);
        expect_byte("init_clear", 8'h01, 1'b0, model_idx, 1'b0, g);
        expect_byte("init_entry", 8'h06, 1'b0, model_idx, 1'b0, g);
    endtask

    task automatic do_pass(input logic [7:0] nv);
        logic [7:0] g;
        n = nv;
        expect_byte("line1_addr", 8'h80, 1'b0, model_idx, 1'b1, g);
        addr_rise = last_rise;
        for (int i = 0; i < 16; i++) begin
            expect_byte($sformatf("l1_pos%0d_n%02h", i, nv), conv(lookup(8'(i), nv)), 1'b1, 8'(i), 1'b1, g);
            line_got[i] = g;
        end
        expect_byte("line2_addr", 8'hC0, 1'b0, model_idx, 1'b1, g);
        for (int i = 16; i < 32; i++) begin
            expect_byte($sformatf("l2_pos%0d_n%02h", i, nv), conv(lookup(8'(i), nv)), 1'b1, 8'(i), 1'b1, g);
            line_got[i] = g;
        end
    endtask

    initial begin
        int t;
        repeat (5) @(negedge clk);
        chk("rst_en", {31'd0, lcd_en}, 32'd0);
        chk("rst_data", {24'd0, lcd_data}, 32'd0);
        chk("rst_rs", {31'd0, lcd_rs}, 32'd0);
        chk("rst_index", {24'd0, lcd_index}, 32'd0);
        chk("rst_ready", {31'd0, ready}, 32'd0);
        chk("const_pins", {29'd0, lcd_rw, lcd_on, lcd_blon}, 32'b010);

        reset_n = 1'b1;
        rel_cyc = cyc;
        do_init();
        do_pass(8'h4A);
        chk("ready_rise_cycle", ready_rise_cyc, addr_rise - T_SETUP);
        chk("l1_hex_hi_4A", {24'd0, line_got[5]}, 32'h34);
        chk("l2_pos22_4A", {24'd0, line_got[22]}, 32'h4A);

        do_pass(8'h9F);
        chk("l1_pos5_9F", {24'd0, line_got[5]}, 32'h39);
        chk("l1_pos6_9F", {24'd0, line_got[6]}, 32'h46);
        do_pass(8'h0A);
        chk("l2_pos22_0A", {24'd0, line_got[22]}, 32'h41);
        do_pass(8'h10);
        chk("l2_pos22_10", {24'd0, line_got[22]}, 32'h10);
        do_pass(8'($urandom_range(0, 15)));
        do_pass(8'($urandom_range(0, 255)));

        t = 0;
        while (!(lcd_en === 1'b1 && lcd_rs === 1'b1) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        chk("find_data_en_hi", {31'd0, lcd_en & lcd_rs}, 32'd1);
        repeat (3) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("midrst_en", {31'd0, lcd_en}, 32'd0);
        chk("midrst_data", {24'd0, lcd_data}, 32'd0);
        chk("midrst_rs", {31'd0, lcd_rs}, 32'd0);
        chk("midrst_index", {24'd0, lcd_index}, 32'd0);
        chk("midrst_ready", {31'd0, ready}, 32'd0);
        repeat (4) @(negedge clk);
        reset_n = 1'b1;
        rel_cyc = cyc;
        have_prev = 0;
        model_idx = 8'd0;
        ready_rise_cyc = -1;
        do_init();
        do_pass(8'($urandom_range(0, 255)));
        chk("ready_rise_cycle_2", ready_rise_cyc, addr_rise - T_SETUP);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
